sysid_checker: RTL and testbench
================================

// Module: sysid_checker
// PURPOSE
//  Avalon-MM read master that interrogates the system-ID slave and verifies the build.
//  - Reads word 0 (system ID) and word 1 (build timestamp).
//  - Compares both against expected parameters.
//  - Reports pass, fail or timeout to the host and status LED logic.
//  - Sits beside the sysid slave on the SS-OCT control fabric.
//  - Gates acquisition start-up until the FPGA image is confirmed.
// PARAMETERS
//  EXPECTED_ID     1193057379  expected 32-bit value at word address 0
//  EXPECTED_TS     1330643110  expected 32-bit value at word address 1
//  TIMEOUT_CYCLES  1023        max clk cycles per read, request to readdatavalid; range 1..65535
//  AUTO_START      1           1: check launches automatically on the first clk after reset release
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous active-high reset
//  start          in   1   single-cycle pulse; launches a check; ignored while busy=1
//  address        out  1   Avalon word address: 0=ID, 1=timestamp
//  read           out  1   Avalon read request
//  waitrequest    in   1   slave stall; read and address held while high
//  readdatavalid  in   1   readdata qualifier; at most one read outstanding
//  readdata       in   32  slave read data
//  busy           out  1   check in progress
//  done           out  1   check finished; held until next launch
//  id_ok          out  1   captured ID == EXPECTED_ID (valid when done=1)
//  ts_ok          out  1   captured timestamp == EXPECTED_TS (valid when done=1)
//  timeout        out  1   a read exceeded TIMEOUT_CYCLES
//  id_value       out  32  last captured ID word
//  ts_value       out  32  last captured timestamp word
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE.
//  - read drops asynchronously with reset, including mid-transfer.
//  FSM: IDLE -> RD_ID_REQ -> RD_ID_WAIT -> RD_TS_REQ -> RD_TS_WAIT -> DONE.
//  Launch:
//  - Occurs on start=1 sampled in IDLE or DONE, or on the first edge after reset if AUTO_START=1.
//  - On launch, clear done/id_ok/ts_ok/timeout/id_value/ts_value; set busy=1.
//  *_REQ states:
//  - read=1, address=0 (ID) or 1 (TS).
//  - The transfer is accepted on the edge where read=1 and waitrequest=0; then read=0 and go to *_WAIT.
//  *_WAIT states:
//  - read=0.
//  - On readdatavalid=1, capture readdata into id_value or ts_value, update id_ok or ts_ok, and advance.
//  - readdatavalid in any state other than *_WAIT is ignored (covers stale data after a timeout).
//  Timeout:
//  - A 16-bit counter clears on entry to each *_REQ state and increments every cycle in *_REQ and *_WAIT.
//  - When the count reaches TIMEOUT_CYCLES: read=0, timeout=1, go to DONE.
//  - ok flags for reads not completed stay 0.
//  DONE: busy=0, done=1; outputs held until the next launch.
//  Latency, zero-wait slave with readdatavalid one cycle after acceptance:
//  - start sampled at edge N -> read high from N.
//  - id captured at N+2; ts captured at N+4.
//  - done=1, busy=0 after edge N+4.
//  Simultaneous events:
//  - start while busy: dropped, no queueing.
//  - readdatavalid and counter reaching the limit on the same edge: the data wins; no timeout.
//  Comparisons are full 32-bit unsigned equality; no masking.
// STRUCTURE
//  - sysid_checker_defs.vh: FSM state encodings (3-bit), address constants ADDR_ID=0 and ADDR_TS=1.
//  - Sub-module sysid_timeout_ctr: clear/enable/limit counter with a 'expired' output.
//  - All other logic, FSM and capture registers, stays in this module.
// TESTING
//  - AUTO_START=1; slave returns 1193057379 / 1330643110 with zero wait
//    -> done at cycle 4, id_ok=1, ts_ok=1, timeout=0.
//  - start pulse; slave returns ID 0x00000000
//    -> id_ok=0, ts_ok=1, id_value=0, done=1.
//  - waitrequest held high 5 cycles on the ID read
//    -> read and address=0 stable throughout; completion delayed by 5 cycles; ok flags set.
//  - TIMEOUT_CYCLES=8; readdatavalid never asserted
//    -> timeout=1 at cycle 8, done=1, ok=0, read=0; a late readdatavalid changes nothing.
//  - reset asserted while in RD_TS_WAIT
//    -> read, busy and all flags go 0 immediately; check relaunches after release.
//  - start pulsed while busy
//    -> ignored; a single check completes with no second read sequence.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// Shared types for the sysid build checker.
// FSM encodings and Avalon word addresses.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_ID_REQ  = 3'd1,
        S_RD_ID_WAIT = 3'd2,
        S_RD_TS_REQ  = 3'd3,
        S_RD_TS_WAIT = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// Per-read watchdog counter.
// expired flags the edge on which the count reaches limit.
module sysid_timeout_ctr (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] cnt;

    assign expired = en && ((cnt + 16'd1) == limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that reads the sysid slave
// and verifies ID and build timestamp.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd1193057379,
    parameter logic [31:0] EXPECTED_TS    = 32'd1330643110,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

    state_t state;
    logic   auto_pend;
    logic   launch;
    logic   ctr_clr;
    logic   ctr_en;
    logic   expired;

    assign launch = ((state == S_IDLE) || (state == S_DONE))
                 && (start || auto_pend);

    assign ctr_en = (state == S_RD_ID_REQ) || (state == S_RD_ID_WAIT)
                 || (state == S_RD_TS_REQ) || (state == S_RD_TS_WAIT);

    // Counter restarts on entry to each request state.
    assign ctr_clr = launch
                  || ((state == S_RD_ID_WAIT) && readdatavalid);

    sysid_timeout_ctr u_ctr (
        .clk     (clk),
        .reset   (reset),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            auto_pend <= AUTO_START;
            address   <= ADDR_ID;
            read      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        auto_pend <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        id_ok     <= 1'b0;
                        ts_ok     <= 1'b0;
                        timeout   <= 1'b0;
                        id_value  <= '0;
                        ts_value  <= '0;
                        read      <= 1'b1;
                        address   <= ADDR_ID;
                        state     <= S_RD_ID_REQ;
                    end
                end
                S_RD_ID_REQ, S_RD_TS_REQ: begin
                    if (expired) begin
                        read    <= 1'b0;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else if (!waitrequest) begin
                        read  <= 1'b0;
                        state <= (state == S_RD_ID_REQ) ?
                                 S_RD_ID_WAIT : S_RD_TS_WAIT;
                    end
                end
                S_RD_ID_WAIT: begin
                    // Returned data beats a same-edge expiry.
                    if (readdatavalid) begin
                        id_value <= readdata;
                        id_ok    <= (readdata == EXPECTED_ID);
                        read     <= 1'b1;
                        address  <= ADDR_TS;
                        state    <= S_RD_TS_REQ;
                    end else if (expired) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_RD_TS_WAIT: begin
                    if (readdatavalid) begin
                        ts_value <= readdata;
                        ts_ok    <= (readdata == EXPECTED_TS);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else if (expired) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                default: begin
                    read  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker with a
// behavioural Avalon slave (stall, no-response, late data).
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd1193057379;
    localparam logic [31:0] EXP_TS = 32'd1330643110;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        to;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        address;
    logic        read;
    logic        waitrequest = 1'b0;
    logic        readdatavalid = 1'b0;
    logic [31:0] readdata = '0;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int launches = 0;
    logic busy_q = 1'b0;
    logic done_q = 1'b0;
    exp_t sb[$];

    logic [31:0] id_word = EXP_ID;
    logic [31:0] ts_word = EXP_TS;
    logic        respond = 1'b1;
    logic        force_rdv = 1'b0;
    int          stall_left = 0;

    sysid_checker #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (8),
        .AUTO_START     (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .address       (address),
        .read          (read),
        .waitrequest   (waitrequest),
        .readdatavalid (readdatavalid),
        .readdata      (readdata),
        .busy          (busy),
        .done          (done),
        .id_ok         (id_ok),
        .ts_ok         (ts_ok),
        .timeout       (timeout),
        .id_value      (id_value),
        .ts_value      (ts_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave: one outstanding read, data the cycle after acceptance.
    initial begin
        logic acc;
        logic adr;
        forever begin
            acc = read && !waitrequest;
            adr = address;
            @(posedge clk);
            #1;
            readdatavalid = 1'b0;
            if (force_rdv) begin
                readdatavalid = 1'b1;
                readdata = EXP_ID;
            end else if (acc && respond && !reset) begin
                readdatavalid = 1'b1;
                readdata = adr ? ts_word : id_word;
            end
            if (read && stall_left > 0) begin
                waitrequest = 1'b1;
                stall_left--;
            end else begin
                waitrequest = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (busy && !busy_q) begin
                start_cyc = cyc;
                launches++;
            end
            if (done && !done_q) begin
                if (sb.size() == 0) begin
                    chk("sb_extra_done", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("id_ok", id_ok, e.id_ok);
                    chk("ts_ok", ts_ok, e.ts_ok);
                    chk("timeout", timeout, e.to);
                    chk("id_value", id_value, e.idv);
                    chk("ts_value", ts_value, e.tsv);
                    chk("busy_done", busy, 0);
                    chk("latency", cyc - start_cyc, e.lat);
                end
            end
        end
        busy_q = busy;
        done_q = done;
    end

    task automatic push(input logic io, input logic to_k,
                        input logic tmo, input logic [31:0] iv,
                        input logic [31:0] tv, input int lat);
        exp_t e;
        e.id_ok = io;
        e.ts_ok = to_k;
        e.to    = tmo;
        e.idv   = iv;
        e.tsv   = tv;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        int l0;
        repeat (3) @(negedge clk);
        chk("rst_read", read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {id_ok, ts_ok, timeout}, 0);
        chk("rst_vals", id_value | ts_value, 0);

        // Auto launch after reset release.
        push(1, 1, 0, EXP_ID, EXP_TS, 4);
        reset = 1'b0;
        wait_sb(40);

        // Bad ID word.
        id_word = 32'h0;
        push(0, 1, 0, 32'h0, EXP_TS, 4);
        pulse_start();
        wait_sb(40);
        id_word = EXP_ID;

        // Five stalled cycles on the ID read.
        stall_left = 5;
        push(1, 1, 0, EXP_ID, EXP_TS, 9);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_read", read, 1);
            chk("stall_addr", address, 0);
        end
        wait_sb(40);

        // No response: watchdog fires, late data ignored.
        respond = 1'b0;
        push(0, 0, 1, 32'h0, 32'h0, 8);
        pulse_start();
        wait_sb(40);
        @(negedge clk);
        chk("to_read", read, 0);
        chk("to_flag", timeout, 1);
        force_rdv = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        force_rdv = 1'b0;
        @(negedge clk);
        chk("late_id_ok", id_ok, 0);
        chk("late_id_val", id_value, 0);
        chk("late_done", done, 1);
        chk("late_busy", busy, 0);
        respond = 1'b1;

        // Reset while in RD_TS_WAIT.
        pulse_start();
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy", busy, 1);
        chk("mid_idv", id_value, EXP_ID);
        reset = 1'b1;
        #1;
        chk("arst_read", read, 0);
        chk("arst_busy", busy, 0);
        chk("arst_flags", {done, id_ok, ts_ok, timeout}, 0);
        chk("arst_idv", id_value, 0);
        push(1, 1, 0, EXP_ID, EXP_TS, 4);
        @(negedge clk);
        reset = 1'b0;
        wait_sb(40);

        // Start while busy is dropped.
        l0 = launches;
        push(1, 1, 0, EXP_ID, EXP_TS, 4);
        pulse_start();
        pulse_start();
        wait_sb(40);
        repeat (10) @(negedge clk);
        chk("one_launch", launches - l0, 1);
        chk("idle_read", read, 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", sb.size());
        $fatal(1);
    end

endmodule
